// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg: shared FSM encoding, region decode and address constants for the GB bus responder
package gb_bus_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EXT_WAIT = 2'd1;
    localparam logic [1:0] ST_IO_ACC   = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    typedef enum logic [1:0] {
        REG_EXT,
        REG_IO,
        REG_HRAM,
        REG_UNMAPPED
    } region_t;

    localparam logic [15:0] ECHO_BASE   = 16'hE000;
    localparam logic [15:0] ECHO_END    = 16'hFDFF;
    localparam logic [15:0] OAM_END     = 16'hFE9F;
    localparam logic [15:0] UNMAP_END   = 16'hFEFF;
    localparam logic [15:0] IO_END      = 16'hFF7F;
    localparam logic [15:0] IE_ADDR     = 16'hFFFF;
    localparam logic [15:0] ECHO_OFFSET = 16'h2000;
    localparam logic [7:0]  FILL_BYTE   = 8'hFF;
    localparam int          HRAM_DEPTH  = 127;

    // Ordered compare chain: each range starts right after the previous one ends.
    function automatic region_t decode_region(input logic [15:0] a);
        return (a <= ECHO_END)                  ? REG_EXT :
               (a <= OAM_END)                   ? REG_IO :
               (a <= UNMAP_END)                 ? REG_UNMAPPED :
               (a <= IO_END || a == IE_ADDR)    ? REG_IO : REG_HRAM;
    endfunction

    // Echo RAM mirrors C000-DDFF.
    function automatic logic [15:0] ext_map(input logic [15:0] a);
        return (a >= ECHO_BASE) ? a - ECHO_OFFSET : a;
    endfunction

endpackage

// File: rtl/gb_hram.sv
// gb_hram: 127x8 high RAM, synchronous write, asynchronous read, never cleared
module gb_hram
    import gb_bus_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:HRAM_DEPTH-1];

    assign rdata = mem[addr];

    // Commit writes on the rising edge; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/gb_bus_responder.sv
// gb_bus_responder: decodes CPU bus requests to external memory, IO or HRAM and returns one response strobe
module gb_bus_responder
    import gb_bus_pkg::*;
#(
    parameter int unsigned WAIT_EXT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        ext_cs,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output logic        io_sel,
    output logic        io_we,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_EXT);

    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [3:0]  cnt_q, cnt_d;
    region_t     req_region;
    logic        accept;
    logic        ext_act;
    logic        io_act;
    logic [7:0]  hram_rdata;

    assign req_region = decode_region(req_addr);
    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign ext_act    = (state_q == ST_EXT_WAIT) && !rst;
    assign io_act     = (state_q == ST_IO_ACC) && !rst;

    assign rsp_valid  = (state_q == ST_RESP) && !rst;
    assign rsp_rdata  = rdata_q;
    assign ext_cs     = ext_act;
    assign ext_we     = ext_act && we_q;
    assign ext_addr   = ext_act ? ext_map(addr_q) : 16'h0000;
    assign ext_wdata  = wdata_q;
    assign io_sel     = io_act;
    assign io_we      = io_act && we_q;
    assign io_addr    = io_act ? addr_q[7:0] : 8'h00;
    assign io_wdata   = wdata_q;

    gb_hram u_hram (
        .clk   (clk),
        .we    (accept && req_we && req_region == REG_HRAM),
        .addr  (req_addr[6:0]),
        .wdata (req_wdata),
        .rdata (hram_rdata)
    );

    // Next-state logic: latch the request on accept, capture read data on entry to RESP.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = (req_region == REG_EXT) ? ST_EXT_WAIT :
                              (req_region == REG_IO)  ? ST_IO_ACC : ST_RESP;
                    rdata_d = (req_region == REG_HRAM && !req_we) ? hram_rdata :
                              (req_region == REG_UNMAPPED || req_region == REG_HRAM) ? FILL_BYTE : rdata_q;
                end
            end
            ST_EXT_WAIT: begin
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? ST_RESP : ST_EXT_WAIT;
                rdata_d = (cnt_q == 4'd0) ? (we_q ? FILL_BYTE : ext_rdata) : rdata_q;
            end
            ST_IO_ACC: begin
                state_d = ST_RESP;
                rdata_d = we_q ? FILL_BYTE : io_rdata;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= FILL_BYTE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gb_bus_responder.sv
// tb_gb_bus_responder: directed vector table plus reset and back-to-back sequences for gb_bus_responder
module tb_gb_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        ext_cs, ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata, ext_rdata;
    logic        io_sel, io_we;
    logic [7:0]  io_addr, io_wdata, io_rdata;

    int checks = 0;
    int failures = 0;

    int ext_cyc = 0, io_cyc = 0, rsp_cnt = 0, acc_cnt = 0, busy_ready = 0, ext_unstable = 0;
    logic        prev_cs = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] ext_addr_cap = '0;
    logic        ext_we_cap = 1'b0;
    logic [7:0]  ext_wd_cap = '0;
    logic [7:0]  io_addr_cap = '0;
    logic        io_we_cap = 1'b0;
    logic [7:0]  io_wd_cap = '0;

    always #5 clk = ~clk;

    gb_bus_responder #(.WAIT_EXT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ext_cs    (ext_cs),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .io_sel    (io_sel),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata)
    );

    // Mid-cycle monitor: free-running event counters, read as deltas by the stimulus.
    always @(negedge clk) begin
        if (ext_cs) begin
            ext_cyc++;
            if (prev_cs && ext_addr !== prev_addr) ext_unstable++;
            ext_addr_cap = ext_addr;
            ext_we_cap = ext_we;
            ext_wd_cap = ext_wdata;
        end
        prev_cs = ext_cs;
        prev_addr = ext_addr;
        if (io_sel) begin
            io_cyc++;
            io_addr_cap = io_addr;
            io_we_cap = io_we;
            io_wd_cap = io_wdata;
        end
        if (rsp_valid) rsp_cnt++;
        if (req_valid && req_ready) acc_cnt++;
        if (req_ready && (ext_cs || io_sel || rsp_valid)) busy_ready++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] a, input logic w, input logic [7:0] d,
                       output int lat, output logic [7:0] rd);
        req_addr = a;
        req_we = w;
        req_wdata = d;
        req_valid = 1'b1;
        #1;
        chk("ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        lat = 0;
        rd = 8'hxx;
        for (int i = 1; i <= 40; i++) begin
            if (rsp_valid) begin
                lat = i;
                rd = rsp_rdata;
                break;
            end
            tick();
        end
        tick();
    endtask

    typedef struct {
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
        logic [7:0]  erd;
        logic [7:0]  ird;
        logic [7:0]  exp;
        int          lat;
        int          ecyc;
        int          icyc;
        logic [15:0] eaddr;
        logic [7:0]  iaddr;
    } vec_t;

    vec_t v [18];

    initial begin
        int lat;
        logic [7:0] rd;
        int e0, i0, r0, a0, u0;

        v[0]  = '{16'h0150, 1'b0, 8'h00, 8'h3C, 8'h00, 8'h3C, 4, 3, 0, 16'h0150, 8'h00};
        v[1]  = '{16'hE123, 1'b0, 8'h00, 8'h77, 8'h00, 8'h77, 4, 3, 0, 16'hC123, 8'h00};
        v[2]  = '{16'hFDFF, 1'b0, 8'h00, 8'h12, 8'h00, 8'h12, 4, 3, 0, 16'hDDFF, 8'h00};
        v[3]  = '{16'hFE00, 1'b0, 8'h00, 8'h00, 8'h44, 8'h44, 2, 0, 1, 16'h0000, 8'h00};
        v[4]  = '{16'hFE9F, 1'b0, 8'h00, 8'h00, 8'h66, 8'h66, 2, 0, 1, 16'h0000, 8'h9F};
        v[5]  = '{16'hFEA0, 1'b0, 8'h00, 8'h11, 8'h22, 8'hFF, 1, 0, 0, 16'h0000, 8'h00};
        v[6]  = '{16'hFEFF, 1'b0, 8'h00, 8'h11, 8'h22, 8'hFF, 1, 0, 0, 16'h0000, 8'h00};
        v[7]  = '{16'hFFFF, 1'b0, 8'h00, 8'h00, 8'h1F, 8'h1F, 2, 0, 1, 16'h0000, 8'hFF};
        v[8]  = '{16'hFF7F, 1'b0, 8'h00, 8'h00, 8'h2B, 8'h2B, 2, 0, 1, 16'h0000, 8'h7F};
        v[9]  = '{16'hFF80, 1'b1, 8'hA5, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 16'h0000, 8'h00};
        v[10] = '{16'hFF80, 1'b0, 8'h00, 8'hAA, 8'hBB, 8'hA5, 1, 0, 0, 16'h0000, 8'h00};
        v[11] = '{16'hFFFE, 1'b1, 8'h5A, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 16'h0000, 8'h00};
        v[12] = '{16'hFFFE, 1'b0, 8'h00, 8'hAA, 8'hBB, 8'h5A, 1, 0, 0, 16'h0000, 8'h00};
        v[13] = '{16'h2000, 1'b1, 8'h99, 8'h3C, 8'h00, 8'hFF, 4, 3, 0, 16'h2000, 8'h00};
        v[14] = '{16'hFF40, 1'b1, 8'h77, 8'h00, 8'h12, 8'hFF, 2, 0, 1, 16'h0000, 8'h40};
        v[15] = '{16'hFEB0, 1'b1, 8'h33, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 16'h0000, 8'h00};
        v[16] = '{16'hDFFF, 1'b0, 8'h00, 8'h81, 8'h00, 8'h81, 4, 3, 0, 16'hDFFF, 8'h00};
        v[17] = '{16'hE000, 1'b0, 8'h00, 8'h82, 8'h00, 8'h82, 4, 3, 0, 16'hC000, 8'h00};

        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        ext_rdata = '0;
        io_rdata = '0;
        repeat (3) tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'hFF);
        chk("rst_ext_cs", 32'(ext_cs), 32'd0);
        chk("rst_io_sel", 32'(io_sel), 32'd0);
        chk("rst_ext_addr", 32'(ext_addr), 32'd0);
        chk("rst_io_addr", 32'(io_addr), 32'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 18; k++) begin
            ext_rdata = v[k].erd;
            io_rdata = v[k].ird;
            e0 = ext_cyc;
            i0 = io_cyc;
            run(v[k].a, v[k].w, v[k].d, lat, rd);
            chk($sformatf("v%0d_rdata", k), 32'(rd), 32'(v[k].exp));
            chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v[k].lat));
            chk($sformatf("v%0d_ext_cycles", k), 32'(ext_cyc - e0), 32'(v[k].ecyc));
            chk($sformatf("v%0d_io_cycles", k), 32'(io_cyc - i0), 32'(v[k].icyc));
            chk($sformatf("v%0d_rdata_hold", k), 32'(rsp_rdata), 32'(v[k].exp));
            if (v[k].ecyc > 0) begin
                chk($sformatf("v%0d_ext_addr", k), 32'(ext_addr_cap), 32'(v[k].eaddr));
                chk($sformatf("v%0d_ext_we", k), 32'(ext_we_cap), 32'(v[k].w));
                if (v[k].w) chk($sformatf("v%0d_ext_wdata", k), 32'(ext_wd_cap), 32'(v[k].d));
            end
            if (v[k].icyc > 0) begin
                chk($sformatf("v%0d_io_addr", k), 32'(io_addr_cap), 32'(v[k].iaddr));
                chk($sformatf("v%0d_io_we", k), 32'(io_we_cap), 32'(v[k].w));
                if (v[k].w) chk($sformatf("v%0d_io_wdata", k), 32'(io_wd_cap), 32'(v[k].d));
            end
        end
        chk("ext_addr_stable", 32'(ext_unstable), 32'd0);

        run(16'hFF86, 1'b1, 8'h22, lat, rd);
        run(16'hFF85, 1'b1, 8'hC3, lat, rd);
        r0 = rsp_cnt;
        ext_rdata = 8'h3C;
        req_addr = 16'h0150;
        req_we = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("abort_cs_first", 32'(ext_cs), 32'd1);
        tick();
        chk("abort_cs_second", 32'(ext_cs), 32'd1);
        rst = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 16'hFF86;
        req_wdata = 8'h11;
        #1;
        chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        chk("abort_cs_after", 32'(ext_cs), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rdata", 32'(rsp_rdata), 32'hFF);
        chk("abort_ext_addr", 32'(ext_addr), 32'd0);
        rst = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        #1;
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        repeat (6) tick();
        chk("abort_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        run(16'hFF85, 1'b0, 8'h00, lat, rd);
        chk("hram_keep_ff85", 32'(rd), 32'hC3);
        run(16'hFF86, 1'b0, 8'h00, lat, rd);
        chk("hram_ignored_wr_ff86", 32'(rd), 32'h22);

        a0 = acc_cnt;
        r0 = rsp_cnt;
        req_addr = 16'hFF80;
        req_we = 1'b0;
        req_valid = 1'b1;
        repeat (20) tick();
        req_valid = 1'b0;
        tick();
        chk("b2b_hram_accepts", 32'(acc_cnt - a0), 32'd10);
        chk("b2b_hram_rsps", 32'(rsp_cnt - r0), 32'd10);
        chk("b2b_hram_rdata", 32'(rsp_rdata), 32'hA5);

        a0 = acc_cnt;
        r0 = rsp_cnt;
        ext_rdata = 8'h5E;
        req_addr = 16'h0150;
        req_valid = 1'b1;
        repeat (15) tick();
        req_valid = 1'b0;
        tick();
        chk("b2b_ext_accepts", 32'(acc_cnt - a0), 32'd3);
        chk("b2b_ext_rsps", 32'(rsp_cnt - r0), 32'd3);
        chk("b2b_ext_rdata", 32'(rsp_rdata), 32'h5E);
        u0 = busy_ready;
        chk("ready_low_when_busy", 32'(u0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
